// File: rtl/gray_stream_decoder_pkg.sv
// Shared types and helpers for the Gray stream decoder and its users.
package gray_pkg;

  // Widest Gray value the helper functions accept.
  localparam int GRAY_MAX_W = 32;

  // Tracking FSM: no reference yet, following a clean stream, fault latched.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Gray to binary over the low w bits: each binary bit is the XOR of all
  // Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] g,
    input int                    w
  );
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  // Binary to Gray over the low w bits.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(
    input logic [GRAY_MAX_W-1:0] b,
    input int                    w
  );
    logic [GRAY_MAX_W-1:0] g;
    g = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (i < w - 1) g[i] = b[i] ^ b[i+1];
      else if (i == w - 1) g[i] = b[i];
    end
    return g;
  endfunction

  // Number of set bits.
  function automatic int popcount(input logic [GRAY_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gray_stream_decoder_gray_to_bin.sv
// Combinational Gray-to-binary leaf used at the decode stage.
module gray_to_bin #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_gray,
  output logic [DATA_WIDTH-1:0] o_bin
);

  logic w_acc;

  // Running XOR from the MSB down produces each binary bit.
  always_comb begin
    o_bin = '0;
    w_acc = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      w_acc    = w_acc ^ i_gray[i];
      o_bin[i] = w_acc;
    end
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Two-stage Gray stream decoder: stage 1 captures the sample, stage 2
// decodes it, reports the modulo step and checks the one-bit-change rule.
// Handshake: in_valid accepts gray_in every cycle it is high (no
// backpressure); out_valid is high for exactly one cycle per accepted
// sample, two cycles after acceptance, with no stall.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  err_clear,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic [DATA_WIDTH-1:0] step,
  output logic                  first,
  output logic                  seq_err,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count,
  output state_e                dbg_state
);

  localparam int DIST_W = $clog2(DATA_WIDTH + 1);

  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_g1;
  logic [DATA_WIDTH-1:0] r_prev_gray;
  logic [DATA_WIDTH-1:0] r_prev_bin;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_bin_out;
  logic [DATA_WIDTH-1:0] r_step;
  logic                  r_first;
  logic                  r_seq_err;
  logic [CNT_WIDTH-1:0]  r_err_count;
  state_e                r_state;

  logic [DATA_WIDTH-1:0] w_bin;
  logic [DATA_WIDTH-1:0] w_step;
  logic [DIST_W-1:0]     w_dist;
  logic                  w_far;
  state_e                w_state_next;
  logic                  w_seq_err;
  logic                  w_first;

  gray_to_bin #(.DATA_WIDTH(DATA_WIDTH)) u_g2b (
    .i_gray (r_g1),
    .o_bin  (w_bin)
  );

  assign w_dist = DIST_W'(popcount(GRAY_MAX_W'(r_g1 ^ r_prev_gray)));
  assign w_far  = (w_dist > DIST_W'(1));
  assign w_step = w_bin - r_prev_bin;

  // Stage 1: capture the incoming sample; the valid bit tracks in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_g1 <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) r_g1 <= gray_in;
    end
  end

  // FSM next state and per-sample flags; a fresh error beats err_clear.
  always_comb begin
    w_state_next = r_state;
    w_seq_err    = 1'b0;
    w_first      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (r_v1) begin
          w_first      = 1'b1;
          w_state_next = TRACK;
        end
      end
      TRACK: begin
        if (r_v1 && w_far) begin
          w_seq_err    = 1'b1;
          w_state_next = FAULT;
        end
      end
      FAULT: begin
        if (r_v1 && w_far) w_seq_err = 1'b1;
        else if (err_clear) w_state_next = TRACK;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  // Stage 2: register outputs and update the reference sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_bin_out   <= '0;
      r_step      <= '0;
      r_first     <= 1'b0;
      r_seq_err   <= 1'b0;
      r_prev_gray <= '0;
      r_prev_bin  <= '0;
    end else begin
      r_out_valid <= r_v1;
      r_seq_err   <= w_seq_err;
      if (r_v1) begin
        r_bin_out   <= w_bin;
        r_step      <= w_first ? '0 : w_step;
        r_first     <= w_first;
        r_prev_gray <= r_g1;
        r_prev_bin  <= w_bin;
      end
    end
  end

  // Saturating error counter; clear and a same-cycle error leave it at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (err_clear) begin
      r_err_count <= w_seq_err ? CNT_WIDTH'(1) : '0;
    end else if (w_seq_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_WIDTH'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign bin_out    = r_bin_out;
  assign step       = r_step;
  assign first      = r_first;
  assign seq_err    = r_seq_err;
  assign err_sticky = (r_state == FAULT);
  assign err_count  = r_err_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: directed sequences then random traffic,
// checked against a cycle-level behavioural model through an expected queue.
module tb_gray_stream_decoder;
  import gray_pkg::*;

  localparam int DW = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic          ov;
    logic [DW-1:0] bin;
    logic [DW-1:0] stp;
    logic          fst;
    logic          serr;
    logic          sticky;
    logic [CW-1:0] cnt;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] gray_in = '0;
  logic          err_clear = 1'b0;
  logic          out_valid;
  logic [DW-1:0] bin_out;
  logic [DW-1:0] step;
  logic          first;
  logic          seq_err;
  logic          err_sticky;
  logic [CW-1:0] err_count;
  state_e        dbg_state;

  always #5 clk = ~clk;

  gray_stream_decoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .gray_in    (gray_in),
    .err_clear  (err_clear),
    .out_valid  (out_valid),
    .bin_out    (bin_out),
    .step       (step),
    .first      (first),
    .seq_err    (seq_err),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on integers: binary value found by searching for the number whose
  // Gray image matches, step as a mod-16 difference, distance as set bits.
  bit        m_pend_v;
  int        m_pend_g;
  bit        m_have_prev;
  int        m_prev_g;
  int        m_prev_b;
  bit        m_fault;
  int        m_cnt;
  int        m_bin, m_stp;
  bit        m_fst;

  function automatic int ref_decode(input int g);
    for (int b = 0; b < (1 << DW); b++)
      if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  task automatic model_cycle(input bit v, input int g, input bit clr, input bit rst);
    exp_t e;
    bit   err;
    bit   ov;
    int   b;
    if (rst) begin
      m_pend_v = 0; m_have_prev = 0; m_prev_g = 0; m_prev_b = 0;
      m_fault = 0; m_cnt = 0; m_bin = 0; m_stp = 0; m_fst = 0;
      err = 0; ov = 0;
    end else begin
      err = 0;
      ov  = m_pend_v;
      if (m_pend_v) begin
        b = ref_decode(m_pend_g);
        if (!m_have_prev) begin
          m_fst = 1; m_stp = 0; m_have_prev = 1;
        end else begin
          m_fst = 0;
          m_stp = (b - m_prev_b + (1 << DW)) % (1 << DW);
          err   = ($countones(m_pend_g ^ m_prev_g) > 1);
        end
        m_bin    = b;
        m_prev_b = b;
        m_prev_g = m_pend_g;
      end
      if (err) m_fault = 1;
      else if (clr) m_fault = 0;
      if (clr) m_cnt = err ? 1 : 0;
      else if (err && m_cnt < (1 << CW) - 1) m_cnt++;
      m_pend_v = v;
      m_pend_g = g;
    end
    e.ov = ov; e.bin = DW'(m_bin); e.stp = DW'(m_stp); e.fst = m_fst;
    e.serr = err; e.sticky = m_fault; e.cnt = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int g, input bit clr, input bit rst);
    @(negedge clk);
    #1;
    reset     = rst;
    in_valid  = v;
    gray_in   = DW'(g);
    err_clear = clr;
    model_cycle(v, g, clr, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic send_list(input int gl[$]);
    foreach (gl[i]) drive(1, gl[i], 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_valid", int'(out_valid), int'(e.ov));
      chk("seq_err", int'(seq_err), int'(e.serr));
      chk("err_sticky", int'(err_sticky), int'(e.sticky));
      chk("err_count", int'(err_count), int'(e.cnt));
      chk("bin_out", int'(bin_out), int'(e.bin));
      chk("step", int'(step), int'(e.stp));
      chk("first", int'(first), int'(e.fst));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int drv_bin;
    int g;
    int mode;

    drive(0, 0, 0, 1);
    // 1: counting from zero.
    send_list('{4'b0000, 4'b0001, 4'b0011, 4'b0010});
    idle(3);
    // 2: wrap-around with a gap.
    drive(0, 0, 0, 1);
    drive(1, 4'b1001, 0, 0);
    drive(1, 4'b1000, 0, 0);
    idle(2);
    drive(1, 4'b0000, 0, 0);
    idle(3);
    // 3: bad jump then a good one.
    drive(0, 0, 0, 1);
    send_list('{4'b0001, 4'b0010, 4'b0110});
    idle(3);
    // 4: clear racing a new error, then a clean clear.
    drive(1, 4'b0000, 0, 0);
    drive(0, 0, 1, 0);
    idle(2);
    drive(0, 0, 1, 0);
    idle(2);
    // 5: saturation.
    send_list('{4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0011});
    idle(3);
    // 6: reset with samples in flight, restart far away.
    drive(1, 4'b0001, 0, 0);
    drive(1, 4'b0011, 0, 0);
    drive(0, 0, 0, 1);
    idle(1);
    drive(1, 4'b1010, 0, 0);
    idle(3);

    // Random traffic: mostly legal increments, some repeats and wild jumps.
    drv_bin = 0;
    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 15);
      if (mode < 9) drv_bin = (drv_bin + 1) % (1 << DW);
      else if (mode == 9) drv_bin = (drv_bin + (1 << DW) - 1) % (1 << DW);
      else if (mode < 13) drv_bin = $urandom_range(0, (1 << DW) - 1);
      g = int'(bin2gray(GRAY_MAX_W'(drv_bin), DW));
      drive($urandom_range(0, 3) != 0, g, $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) == 0);
    end
    idle(3);

    @(negedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_stream_decoder.md
Name: gray_stream_decoder

Overview:
- Receive-side companion to the team's Gray-code counter.
- Samples a Gray-coded count stream, such as a pointer synchronised across a clock domain, and decodes it to binary through a 2-stage pipeline.
- Reports the modulo step since the previous accepted sample.
- Checks that consecutive samples differ by at most one bit, and keeps a sticky fault state plus a saturating error counter for debug and status registers.

Parameters:
- DATA_WIDTH, 4, width of the Gray input, binary output and step.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  gray_in is accepted this cycle; no backpressure, one sample per cycle allowed.
- gray_in  input  DATA_WIDTH  Gray-coded sample.
- err_clear  input  1  clears the fault state and err_count.
- out_valid  output  1  output fields valid this cycle.
- bin_out  output  DATA_WIDTH  binary decode of the sample.
- step  output  DATA_WIDTH  (bin_out - previous accepted bin) mod 2^DATA_WIDTH.
- first  output  1  sample is the first accepted since reset.
- seq_err  output  1  Hamming distance to the previous Gray sample is greater than 1.
- err_sticky  output  1  high while the FSM is in FAULT.
- err_count  output  CNT_WIDTH  count of seq_err events, saturating.

Behaviour:
- Reset, one clk edge with reset=1:
  - Pipeline valids, all outputs, prev_gray, prev_bin and err_count go to 0.
  - FSM goes to EMPTY.
  - A sample in flight is discarded.
  - Reset overrides in_valid and err_clear.
- Stage 1: on in_valid, register gray_in and v1. v1 follows in_valid every cycle.
- Stage 2, when v1=1:
  - Decode gray to binary: b[MSB] = g[MSB]; b[i] = g[i] ^ b[i+1].
  - Compare against prev_gray / prev_bin.
  - Register all output fields and set out_valid=1.
  - Update prev_gray and prev_bin.
- Latency: out_valid is asserted in cycle t+2 for a sample accepted in cycle t. Throughput is 1 sample per cycle.
- When v1=0: out_valid=0; bin_out, step and first hold their last values; seq_err=0; prev state unchanged. Gaps in in_valid are legal and do not disturb the comparison.
- FSM states: EMPTY, TRACK, FAULT.
  - EMPTY, sample arrives: first=1, step=0, seq_err=0, go to TRACK. No check is made.
  - TRACK, sample with distance 0 or 1: seq_err=0, stay in TRACK.
  - TRACK, sample with distance greater than 1: seq_err=1, go to FAULT.
  - FAULT: further samples are still decoded and checked; seq_err pulses on each bad sample.
  - FAULT with err_clear=1 and no seq_err that cycle: go to TRACK.
  - A new error in the same cycle as err_clear wins: state stays FAULT.
  - err_clear in EMPTY or TRACK has no effect on state.
- Distance 0 (repeated value): legal; step=0.
- Wrap-around: the MSB-only transition (e.g. 1000 to 0000 for DATA_WIDTH=4) is distance 1, so step=1 and seq_err=0.
- On an invalid jump, step still reports the modulo binary difference.
- err_count update priority, per cycle:
  - err_clear with seq_err: count = 1.
  - err_clear alone: count = 0.
  - seq_err alone: count increments, saturating at 2^CNT_WIDTH - 1.
- Timing of err_count and err_sticky: they update on the same edge that sets the out_valid/seq_err registers, so they are visible in the same cycle as out_valid.
- Width rules: step uses DATA_WIDTH modulo subtraction. Distance is popcount(gray ^ prev_gray), computed at $clog2(DATA_WIDTH+1) bits and compared against 1.

Decomposition:
- Package gray_pkg holds:
  - state enum {EMPTY, TRACK, FAULT};
  - function gray2bin (parameterised through width);
  - function bin2gray, for bench and reuse;
  - function popcount.
- One combinational leaf sub-module, gray_to_bin (DATA_WIDTH), instanced at stage 2.
- Everything else stays in the top module.

Test Plan (DATA_WIDTH=4, CNT_WIDTH=2 unless stated):
1. Reset, then gray 0000, 0001, 0011, 0010 on consecutive cycles -> out_valid starting 2 cycles later; bin 0,1,2,3; step 0,1,1,1; first 1,0,0,0; seq_err all 0; err_count 0.
2. Gray 1001, 1000, 0000 (bin 14, 15, 0) with 2 idle cycles between the 2nd and 3rd samples -> step (first),1,1; out_valid low during the gap; seq_err 0.
3. Gray 0001 then 0010 (bin 1 to 3, distance 2) -> seq_err pulse on the 2nd output with step=2; err_sticky=1 in the same cycle; err_count=1. Then 0110 (distance 1) -> seq_err 0, err_sticky stays 1.
4. In FAULT, drive err_clear in the cycle the output for another bad sample (0110 to 0000, distance 2) is registered -> err_sticky stays 1, err_count=1. err_clear with no error -> err_sticky 0, err_count 0.
5. Five bad jumps alternating 0000/0011 -> err_count 1,2,3,3,3; seq_err pulses 5 times.
6. Assert reset while 2 samples are in the pipeline -> out_valid 0 from the next cycle, err_count 0, err_sticky 0. The next sample gives first=1, step=0, and no seq_err even if it is far from the pre-reset value.
